ex_stage: RTL

Execute stage of the 5-stage MIPS pipeline, directly downstream of instruction decode. It registers the decode-to-execute bus and evaluates the one-hot ALU operation. It issues the data-SRAM request, forwards its result back to decode, and produces the execute-to-memory bus. It also contains an iterative 32-cycle divider with HI/LO registers, which raises a stall request while a DIV/DIVU is in flight.

---
 rtl/ex_stage_pkg.sv | 68 ++++++
 rtl/div_iter.sv | 117 +++++++++++
 rtl/ex_stage.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// ex_stage_pkg
// Shared definitions for the execute stage of the 5-stage MIPS pipeline:
// bus widths, stall-vector encoding, opcode/func codes, one-hot ALU bit
// positions, the decode-to-execute bus layout and the divider state type.
//
// Optional feature macro used by the stage: EX_DIV_EN (iterative divider,
// HI/LO registers and the execute stall request).
// -----------------------------------------------------------------------------
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_ID_WD  = 38;
  localparam int STALL_BUS    = 6;

  // Stall vector encoding: a 1 in stall[n] freezes pipeline register n.
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;

  // Bit positions inside the one-hot alu_op field (add is the MSB).
  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  // Decode-to-execute bus, MSB first; packs to exactly ID_TO_EX_WD bits.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_alu_src1;  // bit0 rdata1, bit1 pc, bit2 shamt
    logic [3:0]  sel_alu_src2;  // bit0 rdata2, bit1 simm, bit2 8, bit3 zimm
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;    // 1 = result comes from memory (load)
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_to_ex_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Two's-complement negate when neg is set; used for magnitudes and fixup.
  function automatic logic [31:0] negate_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
// Iterative restoring divider, one quotient bit per cycle (32 cycles).
// Only built when EX_DIV_EN is defined.
//
// FSM: IDLE -> BUSY (32 cycles) -> DONE -> IDLE.
//   IDLE : start latches operands (magnitudes for signed) and goes to BUSY.
//   BUSY : one restoring step per cycle; after count 31 goes to DONE.
//   DONE : quotient/remainder presented with sign fixup; waits for leave.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       a DIV/DIVU sits in the EX register
//   is_signed   1 = DIV, 0 = DIVU
//   leave       the instruction in EX advances or is replaced by a bubble
//   a, b        dividend, divisor (raw register values)
//   busy        stall request: start seen in IDLE, or BUSY
//   done        DONE state; quotient/remainder are final
//   quotient    signed-corrected quotient (0xFFFFFFFF on divide by zero)
//   remainder   signed-corrected remainder (dividend on divide by zero)
// -----------------------------------------------------------------------------
`ifdef EX_DIV_EN
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic        leave,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_t  state, state_nxt;
  logic [4:0]  count;
  logic [31:0] quo;          // dividend shifts out, quotient bits shift in
  logic [31:0] rem;
  logic [31:0] divisor;
  logic [31:0] dividend_raw; // kept for the divide-by-zero result
  logic        neg_q, neg_r, div_zero;

  logic [32:0] rem_shift, diff;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      DIV_IDLE: if (start)          state_nxt = DIV_BUSY;
      DIV_BUSY: if (count == 5'd31) state_nxt = DIV_DONE;
      DIV_DONE: if (leave)          state_nxt = DIV_IDLE;
      default:                      state_nxt = DIV_IDLE;
    endcase
  end

  // Restoring step: bring down the next dividend bit, subtract if it fits.
  assign rem_shift = {rem, quo[31]};
  assign diff      = rem_shift - {1'b0, divisor};

  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      quo          <= '0;
      rem          <= '0;
      divisor      <= '0;
      dividend_raw <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div_zero     <= 1'b0;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (start) begin
            count        <= '0;
            quo          <= negate_if(is_signed & a[31], a);
            rem          <= '0;
            divisor      <= negate_if(is_signed & b[31], b);
            dividend_raw <= a;
            neg_q        <= is_signed & (a[31] ^ b[31]);
            neg_r        <= is_signed & a[31];
            div_zero     <= (b == 32'd0);
          end
        end
        DIV_BUSY: begin
          count <= count + 5'd1;
          if (!diff[32]) begin
            rem <= diff[31:0];
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= rem_shift[31:0];
            quo <= {quo[30:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = ((state == DIV_IDLE) && start) || (state == DIV_BUSY);
  assign done      = (state == DIV_DONE);
  assign quotient  = div_zero ? 32'hFFFF_FFFF : negate_if(neg_q, quo);
  assign remainder = div_zero ? dividend_raw  : negate_if(neg_r, rem);

endmodule
`endif

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage
// Execute stage of the 5-stage MIPS pipeline. Registers the decode bus,
// evaluates the one-hot ALU, issues the data-SRAM request, forwards its
// result to decode and drives the execute-to-memory bus.
//
// Optional feature (macro EX_DIV_EN): iterative DIV/DIVU divider with HI/LO
// registers and a stall request while a divide is in flight. Without it,
// DIV/DIVU behave as NOPs, MFHI/MFLO return 0 and stallreq_for_ex is 0.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall[5:0]        pipeline stall vector (stall[2] = EX, stall[3] = MEM)
//   id_to_ex_bus      decoded instruction (159 bits)
//   ex_to_mem_bus     {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, result}
//   ex_to_id_bus      {rf_we, rf_waddr, result} forwarding path
//   ex_is_load        EX holds a load (load-use interlock in decode)
//   stallreq_for_ex   divider busy
//   data_sram_*       data memory request
// -----------------------------------------------------------------------------
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS-1:0]    stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
  output logic                    ex_is_load,
  output logic                    stallreq_for_ex,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);

  id_to_ex_t ex_r;

  // EX stops while MEM runs: the instruction must not be duplicated, so a
  // bubble is inserted instead of holding.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r <= '0;
    end else if (stall[2] == STOP && stall[3] == NO_STOP) begin
      ex_r <= '0;
    end else if (stall[2] == NO_STOP) begin
      ex_r <= id_to_ex_t'(id_to_ex_bus);
    end
  end

  // ---------------------------------------------------------------- operands
  logic [15:0] imm;
  logic [31:0] simm, zimm, src1, src2;

  assign imm  = ex_r.inst[15:0];
  assign simm = {{16{imm[15]}}, imm};
  assign zimm = {16'b0, imm};

  assign src1 = ({32{ex_r.sel_alu_src1[0]}} & ex_r.rdata1)
              | ({32{ex_r.sel_alu_src1[1]}} & ex_r.pc)
              | ({32{ex_r.sel_alu_src1[2]}} & {27'b0, ex_r.inst[10:6]});

  assign src2 = ({32{ex_r.sel_alu_src2[0]}} & ex_r.rdata2)
              | ({32{ex_r.sel_alu_src2[1]}} & simm)
              | ({32{ex_r.sel_alu_src2[2]}} & 32'd8)
              | ({32{ex_r.sel_alu_src2[3]}} & zimm);

  // --------------------------------------------------------------------- ALU
  logic [11:0] op;
  logic [31:0] add_res, sub_res, slt_res, sltu_res, sll_res, srl_res, sra_res,
               lui_res, alu_res;

  assign op       = ex_r.alu_op;
  assign add_res  = src1 + src2;
  assign sub_res  = src1 - src2;
  assign slt_res  = {31'b0, $signed(src1) < $signed(src2)};
  assign sltu_res = {31'b0, src1 < src2};
  assign sll_res  = src2 << src1[4:0];
  assign srl_res  = src2 >> src1[4:0];
  assign sra_res  = $unsigned($signed(src2) >>> src1[4:0]);
  assign lui_res  = {src2[15:0], 16'b0};

  // One-hot AND-OR mux: an all-zero alu_op yields 0.
  assign alu_res = ({32{op[ALU_ADD]}}  & add_res)
                 | ({32{op[ALU_SUB]}}  & sub_res)
                 | ({32{op[ALU_SLT]}}  & slt_res)
                 | ({32{op[ALU_SLTU]}} & sltu_res)
                 | ({32{op[ALU_AND]}}  & (src1 & src2))
                 | ({32{op[ALU_NOR]}}  & ~(src1 | src2))
                 | ({32{op[ALU_OR]}}   & (src1 | src2))
                 | ({32{op[ALU_XOR]}}  & (src1 ^ src2))
                 | ({32{op[ALU_SLL]}}  & sll_res)
                 | ({32{op[ALU_SRL]}}  & srl_res)
                 | ({32{op[ALU_SRA]}}  & sra_res)
                 | ({32{op[ALU_LUI]}}  & lui_res);

  // ------------------------------------------------------- special decoding
  logic is_special, is_mfhi, is_mflo;
  logic [31:0] hi_val, lo_val, ex_result;

  assign is_special = (ex_r.inst[31:26] == OP_SPECIAL);
  assign is_mfhi    = is_special && (ex_r.inst[5:0] == FUNC_MFHI);
  assign is_mflo    = is_special && (ex_r.inst[5:0] == FUNC_MFLO);

`ifdef EX_DIV_EN
  logic        is_div, is_div_signed, ex_leave;
  logic        div_busy, div_done;
  logic [31:0] div_quo, div_rem;
  logic [31:0] hi_r, lo_r;

  assign is_div_signed = is_special && (ex_r.inst[5:0] == FUNC_DIV);
  assign is_div        = is_div_signed || (is_special && (ex_r.inst[5:0] == FUNC_DIVU));
  // The div leaves EX when EX advances or a bubble replaces it.
  assign ex_leave      = (stall[2] == NO_STOP) || (stall[3] == NO_STOP);

  div_iter u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div),
    .is_signed (is_div_signed),
    .leave     (ex_leave),
    .a         (ex_r.rdata1),
    .b         (ex_r.rdata2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // HI/LO commit at the end of DONE, so an MFHI/MFLO entering EX right after
  // the divide already sees the new values.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (div_done) begin
      hi_r <= div_rem;
      lo_r <= div_quo;
    end
  end

  assign hi_val          = hi_r;
  assign lo_val          = lo_r;
  assign stallreq_for_ex = div_busy;
`else
  assign hi_val          = 32'd0;
  assign lo_val          = 32'd0;
  assign stallreq_for_ex = 1'b0;
`endif

  assign ex_result = is_mfhi ? hi_val :
                     is_mflo ? lo_val : alu_res;

  // ----------------------------------------------------------------- outputs
  assign data_sram_en    = ex_r.data_ram_en;
  assign data_sram_wen   = ex_r.data_ram_wen;
  assign data_sram_addr  = ex_r.rdata1 + simm;
  assign data_sram_wdata = ex_r.rdata2;
  assign ex_is_load      = ex_r.sel_rf_res;

  assign ex_to_mem_bus = {ex_r.pc, ex_r.data_ram_en, ex_r.data_ram_wen,
                          ex_r.sel_rf_res, ex_r.rf_we, ex_r.rf_waddr, ex_result};
  assign ex_to_id_bus  = {ex_r.rf_we, ex_r.rf_waddr, ex_result};

  // Stall bits owned by other stages and the rs/rt fields are not needed here.
  logic unused_ok;
  assign unused_ok = ^{stall[5:4], stall[1:0], ex_r.inst[25:16]};

endmodule
